// File: rtl/pixel_merge_buffer_pkg.sv
// pixel_buffer_pkg: shared types and sizing helper for the pixel merge buffer
package pixel_buffer_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;
    function automatic int core_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pixel_merge_buffer_fifo.sv
// pixel_fifo: per-core synchronous FIFO with registered full/empty flags and a frame clear
module pixel_fifo #(
    parameter int DEPTH = 2,
    parameter int PIX_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [PIX_W-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [PIX_W-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0] r_count, w_count_nxt;
    logic r_full, r_empty, w_wr, w_rd;
    assign w_wr = i_wr_en && !r_full && !i_clr;
    assign w_rd = i_rd_en && !r_empty && !i_clr;
    assign w_count_nxt = i_clr ? '0 : r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    // Flags come from the next count so they are registered yet exact
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_count  <= w_count_nxt;
            r_wr_ptr <= i_clr ? '0 : r_wr_ptr + AW'(w_wr);
            r_rd_ptr <= i_clr ? '0 : r_rd_ptr + AW'(w_rd);
            r_full   <= w_count_nxt == (AW+1)'(DEPTH);
            r_empty  <= w_count_nxt == '0;
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
endmodule

// File: rtl/pixel_merge_buffer.sv
// pixel_merge_buffer: round-robin in-order merge of per-core pixel FIFOs into a framed stream
module pixel_merge_buffer
    import pixel_buffer_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int DEPTH     = 2,
    parameter int PIX_W     = 24,
    parameter int DIM_W     = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          start,
    input  logic [core_w(NUM_CORES)-1:0]  cfg_active_m1,
    input  logic [DIM_W-1:0]              cfg_line_m1,
    input  logic [DIM_W-1:0]              cfg_lines_m1,
    input  logic [NUM_CORES*PIX_W-1:0]    in_pix,
    input  logic [NUM_CORES-1:0]          in_valid,
    output logic [NUM_CORES-1:0]          in_ready,
    output logic [PIX_W-1:0]              out_pix,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sof,
    output logic                          out_eol,
    output logic                          frame_done,
    output logic                          busy
);
    localparam int CW = core_w(NUM_CORES);
    localparam logic [CW-1:0] MAX_M1 = CW'(NUM_CORES - 1);
    state_t r_state, w_state_nxt;
    logic [CW-1:0] r_active_m1, r_cur;
    logic [DIM_W-1:0] r_line_m1, r_lines_m1, r_x, r_y;
    logic [PIX_W-1:0] r_out_pix;
    logic r_out_valid, r_done;
    logic [NUM_CORES-1:0] w_full, w_empty, w_wr, w_rd;
    logic [PIX_W-1:0] w_rd_data [NUM_CORES];
    logic w_run, w_last, w_accept, w_final, w_load, w_eol;
    assign w_run    = r_state == RUN;
    assign w_eol    = r_x == r_line_m1;
    assign w_last   = w_eol && r_y == r_lines_m1;
    assign w_accept = r_out_valid && out_ready;
    assign w_final  = w_run && w_accept && w_last;
    // Once the frame's last pixel sits in the output register nothing more may load
    assign w_load   = w_run && !w_empty[r_cur] && (!r_out_valid || out_ready) && !(r_out_valid && w_last);
    always_comb begin
        w_state_nxt = (!w_run && start) ? RUN : (w_final ? IDLE : r_state);
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_active_m1 <= '0;
            r_line_m1   <= '0;
            r_lines_m1  <= '0;
        end else if (!w_run && start) begin
            r_active_m1 <= (cfg_active_m1 > MAX_M1) ? MAX_M1 : cfg_active_m1;
            r_line_m1   <= cfg_line_m1;
            r_lines_m1  <= cfg_lines_m1;
        end
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_pix   <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_cur       <= '0;
            r_x         <= '0;
            r_y         <= '0;
        end else begin
            r_done      <= w_final;
            r_out_valid <= w_load || (r_out_valid && !out_ready);
            if (w_load) r_out_pix <= w_rd_data[r_cur];
            if (w_final) begin
                r_cur <= '0;
                r_x   <= '0;
                r_y   <= '0;
            end else begin
                if (w_load) r_cur <= (r_cur == r_active_m1) ? '0 : r_cur + CW'(1);
                if (w_run && w_accept) begin
                    r_x <= w_eol ? '0 : r_x + DIM_W'(1);
                    r_y <= w_eol ? r_y + DIM_W'(1) : r_y;
                end
            end
        end
    end
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        localparam logic [CW-1:0] IDX = CW'(i);
        assign in_ready[i] = w_run && IDX <= r_active_m1 && !w_full[i];
        assign w_wr[i]     = in_valid[i] && in_ready[i];
        assign w_rd[i]     = w_load && r_cur == IDX;
        pixel_fifo #(.DEPTH(DEPTH), .PIX_W(PIX_W)) u_fifo (
            .i_clk     (aclk),
            .i_rst_n   (aresetn),
            .i_clr     (w_final),
            .i_wr_en   (w_wr[i]),
            .i_wr_data (in_pix[i*PIX_W +: PIX_W]),
            .i_rd_en   (w_rd[i]),
            .o_rd_data (w_rd_data[i]),
            .o_full    (w_full[i]),
            .o_empty   (w_empty[i])
        );
    end
    assign out_pix    = r_out_pix;
    assign out_valid  = r_out_valid;
    assign out_sof    = r_out_valid && r_x == '0 && r_y == '0;
    assign out_eol    = r_out_valid && w_eol;
    assign frame_done = r_done;
    assign busy       = w_run;
endmodule
